divider16_seq: RTL and testbench

DIVIDER16_SEQ -- requirements
Module: divider16_seq

---
 rtl/divider16_pkg.sv | 18 +
 rtl/divider16_step.sv | 22 ++
 rtl/divider16_seq.sv | 115 +++++++++++
 tb/tb_divider16_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/divider16_pkg.sv
// Shared definitions for the sequential 2*DW / DW restoring divider.
package divider16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DW_DEFAULT = 16;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DW_DEFAULT);

endpackage

// File: rtl/divider16_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor when it fits.
module divider16_step #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] rem_in,
    input  logic [DW-1:0] divisor,
    input  logic          next_bit,
    output logic [DW-1:0] rem_out,
    output logic          q_bit
);

    logic [DW:0] shifted;

    // Compare the widened partial remainder against the divisor and restore when it is smaller.
    always_comb begin
        shifted = {rem_in, next_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? DW'(shifted - {1'b0, divisor}) : shifted[DW-1:0];
    end

endmodule

// File: rtl/divider16_seq.sv
// Sequential unsigned divider: 2*DW-bit dividend by DW-bit divisor,
// one quotient bit per clock, valid/ready handshakes on both sides.
module divider16_seq
    import divider16_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_zero,
    output logic          overflow
);

    localparam int CW = cnt_width(DW);

    state_t        state;
    logic [DW-1:0] rem;
    logic [DW-1:0] lo;
    logic [DW-1:0] dsr;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rem_next;
    logic          q_bit;

    // lo holds the not-yet-consumed dividend bits at the top and collects
    // quotient bits at the bottom, so after DW steps it is the quotient.
    divider16_step #(.DW(DW)) u_step (
        .rem_in   (rem),
        .divisor  (dsr),
        .next_bit (lo[DW-1]),
        .rem_out  (rem_next),
        .q_bit    (q_bit)
    );

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            cnt       <= '0;
            rem       <= '0;
            lo        <= '0;
            dsr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[DW-1:0];
                            div_zero  <= 1'b1;
                            overflow  <= 1'b0;
                        end else if (dividend[2*DW-1:DW] >= divisor) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            quotient  <= '1;
                            remainder <= '0;
                            div_zero  <= 1'b0;
                            overflow  <= 1'b1;
                        end else begin
                            state <= CALC;
                            rem   <= dividend[2*DW-1:DW];
                            lo    <= dividend[DW-1:0];
                            dsr   <= divisor;
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    lo  <= {lo[DW-2:0], q_bit};
                    if (cnt == CW'(DW - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= {lo[DW-2:0], q_bit};
                        remainder <= rem_next;
                        div_zero  <= 1'b0;
                        overflow  <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider16_seq.sv
// Directed self-checking bench for divider16_seq.
module tb_divider16_seq;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dsr;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;
    logic        overflow;

    int checks;
    int errors;

    divider16_seq #(.DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: present operands for one edge, then scramble them.
    task automatic applyStimulus(input logic [31:0] a, input logic [15:0] b);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 32'hFFFF_FFFF;
        divisor  = 16'h0000;
    endtask

    // Waits for the result after an acceptance edge and compares everything.
    task automatic checkResult(input vec_t v, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        checkOutput({tag, " in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, lat, v.lat);
        checkOutput({tag, " quotient"}, {16'd0, quotient}, {16'd0, v.q});
        checkOutput({tag, " remainder"}, {16'd0, remainder}, {16'd0, v.r});
        checkOutput({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, v.dz});
        checkOutput({tag, " overflow"}, {31'd0, overflow}, {31'd0, v.ov});
    endtask

    // Called at a negedge while in DONE: take the result for one edge.
    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, " out_valid_cleared"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    vec_t vecs [12];
    vec_t v;

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        vecs[0]  = '{32'd100000,     16'd300,    16'd333,    16'd100,    1'b0, 1'b0, 16};
        vecs[1]  = '{32'hFFFE_0001,  16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b0, 16};
        vecs[2]  = '{32'h0001_0000,  16'd1,      16'hFFFF,   16'h0000,   1'b0, 1'b1, 0};
        vecs[3]  = '{32'h1234_5678,  16'd0,      16'hFFFF,   16'h5678,   1'b1, 1'b0, 0};
        vecs[4]  = '{32'd1000,       16'd10,     16'd100,    16'd0,      1'b0, 1'b0, 16};
        vecs[5]  = '{32'd7,          16'd9,      16'd0,      16'd7,      1'b0, 1'b0, 16};
        vecs[6]  = '{32'h0000_FFFF,  16'd1,      16'hFFFF,   16'h0000,   1'b0, 1'b0, 16};
        vecs[7]  = '{32'hFFFF_FFFF,  16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b1, 0};
        vecs[8]  = '{32'h0001_FFFF,  16'd2,      16'hFFFF,   16'd1,      1'b0, 1'b0, 16};
        vecs[9]  = '{32'd0,          16'd5,      16'd0,      16'd0,      1'b0, 1'b0, 16};
        vecs[10] = '{32'hDEAD_BEEF,  16'hFFFF,   16'hDEAE,   16'h9D9D,   1'b0, 1'b0, 16};
        vecs[11] = '{32'hFFFF_0000,  16'd0,      16'hFFFF,   16'h0000,   1'b1, 1'b0, 0};

        // Reset state
        #12;
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset quotient", {16'd0, quotient}, 32'd0);
        checkOutput("reset remainder", {16'd0, remainder}, 32'd0);
        checkOutput("reset flags", {30'd0, div_zero, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].dvd, vecs[i].dsr);
            checkResult(vecs[i], $sformatf("vec%0d", i));
            consume($sformatf("vec%0d", i));
        end

        // Backpressure in DONE with a pending operand pair, then back-to-back
        @(negedge clk);
        applyStimulus(32'd100000, 16'd300);
        checkResult(vecs[0], "bp");
        dividend = 32'd1000;
        divisor  = 16'd10;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp hold", {out_valid, in_ready, overflow, div_zero, quotient, remainder[11:0]},
                        {1'b1, 1'b0, 1'b0, 1'b0, 16'd333, 12'd100});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp no_same_edge_accept", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 32'hFFFF_FFFF;
        divisor  = 16'h0000;
        checkResult(vecs[4], "b2b");
        consume("b2b");

        // Reset mid-CALC: no result, then first edge after release accepts
        @(negedge clk);
        applyStimulus(32'hDEAD_BEEF, 16'hFFFF);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst state", {out_valid, in_ready, div_zero, overflow, quotient, remainder[11:0]},
                    {1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 12'd0});
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                errors++;
                $display("[TB] FAIL midrst out_valid got 1 expected 0");
            end
        end
        checks++;
        dividend = 32'd1000;
        divisor  = 16'd10;
        in_valid = 1'b1;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 32'hFFFF_FFFF;
        divisor  = 16'h0000;
        v = vecs[4];
        checkResult(v, "postrst");
        consume("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
